sensor_monitor: RTL

Sequencing controller around the 4-input sensor error function, error = s[0] | (s[1] & s[3]) | (s[1] & s[2]). It samples the sensor bus on a divided tick and debounces the error over consecutive samples. On a confirmed error it latches a fault snapshot and holds an alarm until software clears it. After the clear it waits for a clean sample before resuming monitoring. It sits between the raw sensor inputs and the system alarm/interrupt logic.

---
 rtl/sensor_monitor.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/sensor_monitor.sv
// -----------------------------------------------------------------------------
// sensor_monitor
//
// Sequencing controller around the 4-input sensor error function
//    err = s[0] | (s[1] & s[3]) | (s[1] & s[2])
// The sensor bus is registered every clock. The registered copy is judged on a
// divided sample tick. An error must persist for DEBOUNCE consecutive ticks
// before a fault is declared. A fault latches a snapshot of the sensors, bumps
// a saturating fault counter and holds the alarm until software clears it.
// After the clear, the block waits for one clean tick before it resumes
// monitoring.
//
// Parameters
//    SAMPLE_DIV  clocks per sample tick (>=1; 1 = sample every clock)
//    DEBOUNCE    consecutive erroring ticks that declare a fault (>=1)
//    CNT_W       width of the saturating fault counter
//
// Ports
//    clk          in   system clock, rising edge
//    n_rst        in   asynchronous active-low reset
//    sensors      in   [3:0] raw sensor bus
//    enable       in   monitoring enable
//    clear        in   fault acknowledge, level-sampled every clock
//    alarm        out  registered, high only in FAULT
//    fault_code   out  [3:0] sensor snapshot captured at fault entry
//    fault_count  out  [CNT_W-1:0] faults declared, saturating
//    monitoring   out  high in MONITOR, PENDING or RECOVER
// -----------------------------------------------------------------------------
module sensor_monitor #(
   parameter int SAMPLE_DIV = 4,
   parameter int DEBOUNCE   = 3,
   parameter int CNT_W      = 8
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic [3:0]       sensors,
   input  logic             enable,
   input  logic             clear,
   output logic             alarm,
   output logic [3:0]       fault_code,
   output logic [CNT_W-1:0] fault_count,
   output logic             monitoring
);

   // Counter widths. A 1-bit floor keeps the vectors legal when the
   // parameter is 1.
   localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam int DEB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
   // deb_cnt holds the count of erroring ticks seen so far. The tick that
   // would bring it to DEBOUNCE declares the fault, so the largest value it
   // ever stores is DEBOUNCE-1.
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      MONITOR = 3'd1,
      PENDING = 3'd2,
      FAULT   = 3'd3,
      RECOVER = 3'd4
   } state_t;

   state_t           state, state_nx;
   logic [3:0]       sens_q;
   logic [DIV_W-1:0] div_cnt, div_nx;
   logic [DEB_W-1:0] deb_cnt, deb_nx;
   logic             alarm_nx;
   logic [3:0]       code_nx;
   logic [CNT_W-1:0] count_nx;
   logic             err;
   logic             tick;
   logic             fault_entry;

   // The error is judged from the registered sensors, so the inputs must be
   // stable one clock before the tick edge that samples them.
   assign err  = sens_q[0] | (sens_q[1] & sens_q[3]) | (sens_q[1] & sens_q[2]);
   assign tick = (SAMPLE_DIV == 1) ? 1'b1 : (div_cnt == DIV_LAST);

   // Decoded from the state register only, so no input reaches this output
   // combinationally.
   assign monitoring = (state == MONITOR) || (state == PENDING) ||
                       (state == RECOVER);

   // ---------------------------------------------------------------- regs
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state       <= IDLE;
         sens_q      <= '0;
         div_cnt     <= '0;
         deb_cnt     <= '0;
         alarm       <= 1'b0;
         fault_code  <= '0;
         fault_count <= '0;
      end else begin
         state       <= state_nx;
         sens_q      <= sensors;
         div_cnt     <= div_nx;
         deb_cnt     <= deb_nx;
         alarm       <= alarm_nx;
         fault_code  <= code_nx;
         fault_count <= count_nx;
      end
   end

   // ---------------------------------------------------------- next state
   always_comb begin
      state_nx    = state;
      deb_nx      = deb_cnt;
      alarm_nx    = alarm;
      code_nx     = fault_code;
      count_nx    = fault_count;
      fault_entry = 1'b0;

      // The divider is parked at 0 while idle or faulted. That way RECOVER
      // and MONITOR always start a full sample period after entry. A disable
      // also parks it, because the next state is IDLE.
      if ((state == IDLE) || (state == FAULT) || !enable || tick)
         div_nx = '0;
      else
         div_nx = div_cnt + DIV_W'(1);

      case (state)
         IDLE: begin
            if (enable)
               state_nx = MONITOR;
            if (clear) begin
               count_nx = '0;
               code_nx  = '0;
            end
         end

         MONITOR: begin
            if (!enable) begin
               state_nx = IDLE;
               deb_nx   = '0;
            end else if (tick && err) begin
               if (DEBOUNCE == 1) begin
                  fault_entry = 1'b1;
               end else begin
                  state_nx = PENDING;
                  deb_nx   = DEB_W'(1);
               end
            end
         end

         PENDING: begin
            // A disable takes priority over an erroring tick on the same edge.
            if (!enable) begin
               state_nx = IDLE;
               deb_nx   = '0;
            end else if (tick) begin
               if (!err) begin
                  // A clean tick breaks the run, so isolated bursts never add up.
                  state_nx = MONITOR;
                  deb_nx   = '0;
               end else if (deb_cnt == DEB_LAST) begin
                  fault_entry = 1'b1;
                  deb_nx      = '0;
               end else begin
                  deb_nx = deb_cnt + DEB_W'(1);
               end
            end
         end

         FAULT: begin
            // Enable is ignored here and the sensors are not judged. Only an
            // acknowledge releases the latched alarm.
            if (clear) begin
               state_nx = RECOVER;
               alarm_nx = 1'b0;
            end
         end

         RECOVER: begin
            if (!enable) begin
               state_nx = IDLE;
               deb_nx   = '0;
            end else if (tick && !err) begin
               state_nx = MONITOR;
            end
         end

         default: begin
            state_nx = IDLE;
            deb_nx   = '0;
         end
      endcase

      // Fault entry actions happen on the same edge as the move into FAULT.
      // The snapshot is the sensor value that was judged on this tick.
      if (fault_entry) begin
         state_nx = FAULT;
         alarm_nx = 1'b1;
         code_nx  = sens_q;
         if (fault_count != {CNT_W{1'b1}})
            count_nx = fault_count + CNT_W'(1);
      end
   end

endmodule
